// File: rtl/onewire_if.sv
// onewire_if: sequencer command handshake plus DQ pad pins (cmd_valid/cmd/wr_data/dq_in in, cmd_ready/done/rd_data/presence/dq_oe out of the master)
interface onewire_if;
  logic       cmd_valid;
  logic [1:0] cmd;
  logic [7:0] wr_data;
  logic       cmd_ready;
  logic       done;
  logic [7:0] rd_data;
  logic       presence;
  logic       dq_oe;
  logic       dq_in;
  modport master (
    input  cmd_valid, cmd, wr_data, dq_in,
    output cmd_ready, done, rd_data, presence, dq_oe
  );
  modport slave (
    output cmd_valid, cmd, wr_data, dq_in,
    input  cmd_ready, done, rd_data, presence, dq_oe
  );
endinterface

// File: rtl/onewire_master.sv
// onewire_master: 1-Wire byte master (bus reset with presence, write byte, read byte) timed by tick_1us; ports clk, rst, tick_1us, bus (onewire_if.master)
module onewire_master #(
  parameter int T_RST_LOW  = 480,
  parameter int T_PRES_SMP = 70,
  parameter int T_RST_REL  = 410,
  parameter int T_SLOT     = 70,
  parameter int T_W0_LOW   = 60,
  parameter int T_W1_LOW   = 6,
  parameter int T_RD_SMP   = 15,
  parameter int T_REC      = 2
) (
  input logic       clk,
  input logic       rst,
  input logic       tick_1us,
  onewire_if.master bus
);
  typedef enum logic [2:0] {IDLE, RST_LOW, RST_REL, SLOT, REC} state_t;
  state_t     state, state_n;
  logic [9:0] cnt, cnt_n, cnt_inc, low;
  logic [2:0] bitc, bitc_n;
  logic [7:0] sh, sh_n, wd, wd_n, rd, rd_n;
  logic [1:0] op, op_n;
  logic       oe, oe_n, rdy, rdy_n, dn, dn_n, pres, pres_n, acc, rd_op;
  assign cnt_inc       = cnt + 10'd1;
  assign acc           = state == IDLE && bus.cmd_valid;
  assign rd_op         = op == 2'b10;
  assign low           = (rd_op || wd[bitc]) ? 10'(T_W1_LOW) : 10'(T_W0_LOW);
  assign bus.cmd_ready = rdy;
  assign bus.done      = dn;
  assign bus.rd_data   = rd;
  assign bus.presence  = pres;
  assign bus.dq_oe     = oe;
  always_comb begin
    state_n = state;
    bitc_n  = bitc;
    sh_n    = sh;
    wd_n    = wd;
    rd_n    = rd;
    op_n    = op;
    oe_n    = oe;
    pres_n  = pres;
    dn_n    = 1'b0;
    case (state)
      IDLE: if (bus.cmd_valid) begin
        op_n    = bus.cmd;
        wd_n    = bus.wr_data;
        bitc_n  = '0;
        state_n = bus.cmd == 2'b00 ? RST_LOW : bus.cmd == 2'b11 ? IDLE : SLOT;
        oe_n    = bus.cmd != 2'b11;
        dn_n    = bus.cmd == 2'b11;
      end
      RST_LOW: if (tick_1us && cnt_inc == 10'(T_RST_LOW)) begin
        state_n = RST_REL;
        oe_n    = 1'b0;
      end
      RST_REL: begin
        if (tick_1us && cnt_inc == 10'(T_PRES_SMP)) pres_n = !bus.dq_in;
        if (tick_1us && cnt_inc == 10'(T_RST_REL)) begin
          state_n = IDLE;
          dn_n    = 1'b1;
        end
      end
      SLOT: begin
        if (tick_1us && cnt_inc == low) oe_n = 1'b0;
        if (rd_op && tick_1us && cnt_inc == 10'(T_RD_SMP)) sh_n = {bus.dq_in, sh[7:1]};
        if (tick_1us && cnt_inc == 10'(T_SLOT)) begin
          state_n = REC;
          oe_n    = 1'b0;
        end
      end
      REC: if (tick_1us && cnt_inc == 10'(T_REC)) begin
        if (bitc == 3'd7) begin
          state_n = IDLE;
          dn_n    = 1'b1;
          rd_n    = rd_op ? sh : rd;
        end else begin
          state_n = SLOT;
          bitc_n  = bitc + 3'd1;
          oe_n    = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    cnt_n = (acc || state_n != state) ? '0 : tick_1us ? cnt_inc : cnt;
    rdy_n = state_n == IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      bitc  <= '0;
      sh    <= '0;
      wd    <= '0;
      rd    <= '0;
      op    <= '0;
      oe    <= 1'b0;
      rdy   <= 1'b1;
      dn    <= 1'b0;
      pres  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      bitc  <= bitc_n;
      sh    <= sh_n;
      wd    <= wd_n;
      rd    <= rd_n;
      op    <= op_n;
      oe    <= oe_n;
      rdy   <= rdy_n;
      dn    <= dn_n;
      pres  <= pres_n;
    end
  end
endmodule
